uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clk cycles per serial bit (27 MHz / 115200); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data  input  8  byte to transmit.
REQ-006 data_valid  input  1  data is presented for transfer.
REQ-007 data_ready  output  1  buffer can accept a byte (not full).
REQ-008 tx_pin  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  frame in progress or buffer non-empty.
REQ-010 tx_done  output  1  one-cycle pulse when a stop bit completes.

Function
REQ-011 A byte shall be accepted on a rising edge where data_valid and data_ready are both 1; no other edge changes buffer contents on the write side.
REQ-012 data_valid while data_ready=0 shall be ignored, with no state change.
REQ-013 data_ready shall be 0 exactly when the buffer holds FIFO_DEPTH entries; a write is refused when full even if a pop occurs on the same edge.
REQ-014 The state machine shall use states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-015 In IDLE with the buffer non-empty, the next edge shall pop one byte, enter START, and drive tx_pin low; this gives a latency of 1 edge from acceptance into an empty buffer.
REQ-016 Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 A bit counter (0..7) shall advance in DATA; after bit 7, go to PARITY (macro) or STOP.
REQ-018 At the edge ending the stop bit, tx_done shall pulse for 1 cycle; if the buffer is non-empty, pop and enter START on that same edge with no idle gap, otherwise go to IDLE.
REQ-019 busy = (state != IDLE) or (buffer non-empty).
REQ-020 Buffer pointers shall wrap modulo FIFO_DEPTH; the occupancy count is log2(FIFO_DEPTH)+1 bits wide.
REQ-021 A simultaneous push and pop on a non-full buffer shall leave the count unchanged and both operations shall take effect.

Reset
REQ-022 While rst=1 at an edge: state=IDLE, tx_pin=1, buffer flushed, data_ready=1, busy=0, tx_done=0, counters=0.
REQ-023 Reset mid-frame shall abandon the frame immediately, with tx_pin high from the reset edge and no tx_done.

Configuration
REQ-024 With UART_TX_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) shall be sent in PARITY between the data bits and stop, giving an 11-bit frame.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state and its logic shall be absent, giving a 10-bit frame.

Structure
REQ-026 A shared package uart_pkg shall hold the state enumeration, the default CLKS_PER_BIT (234), and the frame bit constants (START=0, STOP=1), shared with uart_rx.
REQ-027 The buffer shall be a sub-module, uart_tx_fifo, with push/pop/full/empty ports; the shifter and state machine stay in uart_tx.

Verification
REQ-028 CLKS_PER_BIT=4, send 0x55 accepted at edge E0 -> tx_pin from E1: 0,1,0,1,0,1,0,1,0,1, each 4 cycles; tx_done pulses at E41.
REQ-029 data_valid held with 0x30..0x35 -> 5 bytes accepted on consecutive edges, data_ready low after the 5th; 0x35 accepted when the first frame ends; 6 frames back-to-back with no idle cycles; 6 tx_done pulses.
REQ-030 rst asserted during data bit 3 of 0xA3 -> tx_pin=1, busy=0, data_ready=1 at the next edge; no tx_done; the next byte 0x31 is sent correctly.
REQ-031 UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, 11-bit frame (44 cycles at CLKS_PER_BIT=4); undefined -> 10 bits (40 cycles).
REQ-032 Buffer full, data_valid=1 with 0xFF -> not accepted, count stays 4, 0xFF never appears on tx_pin.
REQ-033 Default CLKS_PER_BIT=234, send "9" (0x39) -> every bit period measures exactly 234 cycles; the frame is 2340 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter and receiver: default bit timing,
// line levels for start/stop bits, and the framing state machine encoding.
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 234;

   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   function automatic logic evenParity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. The read data is the current
// head entry, so a pop consumes the byte that is visible on rdata_o.
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] wdata_i,
   input  logic       pop_i,
   output logic [7:0] rdata_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] rdPtr_q;
   logic [CW-1:0] count_q;
   logic          pushEn;
   logic          popEn;

   // A push is refused while full even if the same edge pops, so the
   // writer never depends on the reader's timing.
   assign pushEn  = push_i && !full_o;
   assign popEn   = pop_i && !empty_o;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushEn) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (popEn) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({pushEn, popEn})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pushEn) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter. Defining UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit (8E1 framing).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx_pin,
   output logic       busy,
   output logic       tx_done
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [2:0]       state_q,  state_d;
   logic [CNT_W-1:0] clkCnt_q, clkCnt_d;
   logic [2:0]       bitCnt_q, bitCnt_d;
   logic [7:0]       txByte_q, txByte_d;
   logic             txPin_q,  txPin_d;
   logic             txDone_q, txDone_d;

   logic             fifoPop;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [7:0]       fifoData;
   logic             bitEnd;

   uart_tx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (data_valid),
      .wdata_i (data),
      .pop_i   (fifoPop),
      .rdata_o (fifoData),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign bitEnd     = (clkCnt_q == LAST_CNT);
   assign data_ready = !fifoFull;
   assign busy       = (state_q != ST_IDLE) || !fifoEmpty;
   assign tx_pin     = txPin_q;
   assign tx_done    = txDone_q;

   // The next line level is decided here and registered, so tx_pin changes
   // exactly on the edge that enters each bit.
   always_comb begin
      state_d  = state_q;
      clkCnt_d = (state_q == ST_IDLE || bitEnd) ? '0 : clkCnt_q + 1'b1;
      bitCnt_d = bitCnt_q;
      txByte_d = txByte_q;
      txPin_d  = txPin_q;
      txDone_d = 1'b0;
      fifoPop  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifoEmpty) begin
               fifoPop  = 1'b1;
               txByte_d = fifoData;
               txPin_d  = UART_START_BIT;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bitEnd) begin
               bitCnt_d = 3'd0;
               txPin_d  = txByte_q[0];
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bitEnd) begin
               if (bitCnt_q == 3'd7) begin
                  bitCnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                  txPin_d  = evenParity(txByte_q);
                  state_d  = ST_PARITY;
`else
                  txPin_d  = UART_STOP_BIT;
                  state_d  = ST_STOP;
`endif
               end else begin
                  bitCnt_d = bitCnt_q + 3'd1;
                  txPin_d  = txByte_q[bitCnt_q + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bitEnd) begin
               txPin_d = UART_STOP_BIT;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // A queued byte starts on the same edge the stop bit ends.
            if (bitEnd) begin
               txDone_d = 1'b1;
               if (!fifoEmpty) begin
                  fifoPop  = 1'b1;
                  txByte_d = fifoData;
                  txPin_d  = UART_START_BIT;
                  state_d  = ST_START;
               end else begin
                  txPin_d  = UART_STOP_BIT;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: begin
            txPin_d = UART_STOP_BIT;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         clkCnt_q <= '0;
         bitCnt_q <= '0;
         txByte_q <= '0;
         txPin_q  <= UART_STOP_BIT;
         txDone_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         clkCnt_q <= clkCnt_d;
         bitCnt_q <= bitCnt_d;
         txByte_q <= txByte_d;
         txPin_q  <= txPin_d;
         txDone_q <= txDone_d;
      end
   end

endmodule
